rate_enable_gen: RTL and testbench
==================================

// Module: rate_enable_gen
// PURPOSE
//  Upstream pacing stage for the 8-bit T-flip-flop counter. It turns the board clock into a
//  single-cycle count-enable pulse at a selectable rate, so the counter advances at human-visible
//  speeds. Run/pause and single-step are driven from push-buttons.
//  The enable output connects directly to the counter's enable input; both blocks share one clock.
// PARAMETERS
//  CLK_HZ  50_000_000  clock cycles per second; base period P1 = CLK_HZ
//  CNT_W   28          down-counter width; must satisfy 2**CNT_W > 4*CLK_HZ-1
// PORTS
//  clock     in   1      system clock, rising-edge
//  clearb    in   1      reset, asynchronous, active-low
//  rate_sel  in   2      00: P=1, 01: P=CLK_HZ, 10: P=2*CLK_HZ, 11: P=4*CLK_HZ
//  run_key   in   1      active-high button level (async); rising edge toggles pause/run
//  step_key  in   1      active-high button level (async); rising edge requests one pulse while paused
//  enable    out  1      registered count-enable pulse to the counter
//  running   out  1      1 while in RUN state
// BEHAVIOUR
//  Reset (clearb=0, async): state=IDLE, enable=0, running=0, cnt=0, rate_q=rate_sel's reset value 00.
//   All key synchroniser and edge-history flops reset to 1, so a key held through reset release
//   produces no edge.
//  Keys: each key passes through a 2-FF synchroniser plus a previous-value flop; rise = sync & ~prev.
//   A key rising edge reaches a state change on the 3rd rising clock edge after the key goes high.
//  rate_q: rate_sel registered every cycle. R = reload(rate_q) = P-1.
//  FSM states: IDLE, RUN, STEP.
//   IDLE: cnt<=R, enable<=0.
//     run rise -> RUN.
//     step rise (no run rise) -> STEP.
//     run and step rising together -> RUN; the step request is dropped.
//   RUN: if run rise, go to IDLE and set enable<=0.
//     Otherwise, if rate_sel!=rate_q (rate change): cnt<=reload(rate_sel), enable<=0.
//     Otherwise, if cnt==0: cnt<=R, enable<=1.
//     Otherwise: cnt<=cnt-1, enable<=0.
//     step rises are ignored in RUN.
//   STEP: enable<=1, cnt<=R, go to IDLE unconditionally. Edges arriving during STEP are dropped.
//  Timing: if the state becomes RUN at cycle 0, enable is first high at cycle P. It is then high
//   for exactly one cycle every P cycles.
//   P=1: enable is high on every cycle from cycle 1 onward.
//  Step timing: with the edge detected at cycle t, state=STEP at t+1, enable=1 at t+2 (one cycle only).
//  Pausing: leaving RUN clears enable on the next edge. No partial count is retained; re-entering
//   RUN restarts a full period.
//  running = (state==RUN), registered.
//  enable never exceeds one cycle high except when P=1.
// TESTING (sim with CLK_HZ=4; periods 1/4/8/16)
//  1. clearb=0 with run_key=1 held, then release clearb
//     -> enable=0 and running=0 during reset; stays IDLE for 20 cycles.
//  2. rate_sel=01, pulse run_key -> running=1 on the 3rd edge after the rise;
//     enable high for 1 cycle at +4, +8, +12 cycles; pulse run_key again -> enable stays 0.
//  3. rate_sel=00 in RUN -> enable=1 on every cycle from 1 cycle after running rises;
//     cycles with enable=1 equal the cycles elapsed minus 1.
//  4. IDLE, pulse step_key -> exactly one enable cycle 2 cycles after edge detect.
//     step_key pulsed during RUN -> no extra pulse, period unchanged.
//  5. RUN at rate 01, switch to 11 when cnt==1 -> no pulse for 16 cycles, then period 16.
//     run and step rising on the same cycle in IDLE -> RUN, no step pulse.
//  6. clearb=0 mid-RUN while enable=1 -> enable=0 and running=0 before the next clock edge.
//     After release, pulses restart only after a new run rise.

Source files
------------

// File: rtl/rate_enable_gen.sv
// rate_enable_gen
//   Paces the downstream 8-bit counter: produces a registered, single-cycle
//   count-enable pulse every P clock cycles, with P chosen by rate_sel.
//   Run/pause and single-step come from asynchronous push-button levels.
//
// Ports
//   clock     system clock, rising edge
//   clearb    asynchronous active-low reset
//   rate_sel  00: P=1, 01: P=CLK_HZ, 10: P=2*CLK_HZ, 11: P=4*CLK_HZ
//   run_key   button level; rising edge toggles pause/run
//   step_key  button level; rising edge requests one pulse while paused
//   enable    registered count-enable pulse
//   running   high while in RUN
module rate_enable_gen #(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned CNT_W  = 28
) (
  input  logic       clock,
  input  logic       clearb,
  input  logic [1:0] rate_sel,
  input  logic       run_key,
  input  logic       step_key,
  output logic       enable,
  output logic       running
);

  typedef enum logic [1:0] {IDLE, RUN, STEP} state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             enable_d;
  logic [1:0]       rate_q;

  logic run_s1, run_s2, run_prev;
  logic step_s1, step_s2, step_prev;
  logic run_rise, step_rise;

  // Down-counter reload value: period minus one.
  function automatic logic [CNT_W-1:0] reload(input logic [1:0] sel);
    case (sel)
      2'b00:   reload = '0;
      2'b01:   reload = CNT_W'(CLK_HZ - 1);
      2'b10:   reload = CNT_W'(2 * CLK_HZ - 1);
      default: reload = CNT_W'(4 * CLK_HZ - 1);
    endcase
  endfunction

  // Key synchronisers reset high so a key held through reset release
  // does not look like a fresh press.
  always_ff @(posedge clock or negedge clearb) begin
    if (!clearb) begin
      run_s1    <= 1'b1;
      run_s2    <= 1'b1;
      run_prev  <= 1'b1;
      step_s1   <= 1'b1;
      step_s2   <= 1'b1;
      step_prev <= 1'b1;
    end else begin
      run_s1    <= run_key;
      run_s2    <= run_s1;
      run_prev  <= run_s2;
      step_s1   <= step_key;
      step_s2   <= step_s1;
      step_prev <= step_s2;
    end
  end

  assign run_rise  = run_s2 & ~run_prev;
  assign step_rise = step_s2 & ~step_prev;

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    enable_d = 1'b0;
    case (state)
      IDLE: begin
        cnt_d = reload(rate_q);
        // Simultaneous run and step: run wins, step is dropped.
        if (run_rise)       state_d = RUN;
        else if (step_rise) state_d = STEP;
      end
      RUN: begin
        if (run_rise) begin
          state_d = IDLE;
          cnt_d   = reload(rate_q);
        end else if (rate_sel != rate_q) begin
          // Rate change restarts a full period at the new rate.
          cnt_d = reload(rate_sel);
        end else if (cnt == '0) begin
          cnt_d    = reload(rate_q);
          enable_d = 1'b1;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      STEP: begin
        enable_d = 1'b1;
        cnt_d    = reload(rate_q);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clearb) begin
    if (!clearb) begin
      state   <= IDLE;
      cnt     <= '0;
      enable  <= 1'b0;
      running <= 1'b0;
      rate_q  <= 2'b00;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      enable  <= enable_d;
      running <= (state_d == RUN);
      rate_q  <= rate_sel;
    end
  end

endmodule

// File: tb/tb_rate_enable_gen.sv
module tb_rate_enable_gen;

  logic       clock;
  logic       clearb;
  logic [1:0] rate_sel;
  logic       run_key;
  logic       step_key;
  logic       enable;
  logic       running;

  int total = 0;
  int bad   = 0;

  // Expected {enable, running} per observed cycle.
  logic [1:0] sb[$];

  rate_enable_gen #(.CLK_HZ(4), .CNT_W(5)) dut (
    .clock    (clock),
    .clearb   (clearb),
    .rate_sel (rate_sel),
    .run_key  (run_key),
    .step_key (step_key),
    .enable   (enable),
    .running  (running)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog sim time got expired required finish");
    $fatal(1);
  end

  // Drive inputs for the next edge, then wait until 1 time unit after it.
  task automatic drive(input logic rk, input logic sk, input logic [1:0] rs);
    run_key  = rk;
    step_key = sk;
    rate_sel = rs;
    @(posedge clock);
    #1;
  endtask

  // Two-cycle key pulse starting at iteration s.
  function automatic logic at2(input int j, input int s);
    return (j == s) || (j == s + 1);
  endfunction

  // Cycles j in [rs,re] running; pulses at p0, p0+per, ... up to pend.
  task automatic plan_run(input int n, input int rs, input int re,
                          input int p0, input int per, input int pend);
    for (int j = 0; j < n; j++) begin
      logic en, rn;
      rn = (j >= rs) && (j <= re);
      en = (j >= p0) && (j <= pend) && (((j - p0) % per) == 0);
      sb.push_back({en, rn});
    end
  endtask

  task automatic test_reset;
    logic [1:0] exp;
    clearb = 1'b0; run_key = 1'b1; step_key = 1'b0; rate_sel = 2'b00;
    repeat (3) @(posedge clock);
    #1;
    total++;
    if ({enable, running} !== 2'b00) begin
      bad++;
      $display("FAIL reset_hold got en/run=%b%b required 00", enable, running);
    end
    clearb = 1'b1;
    for (int j = 0; j < 23; j++) sb.push_back(2'b00);
    for (int j = 0; j < 23; j++) begin
      drive(j < 20, 1'b0, 2'b00);
      exp = sb.pop_front();
      total++;
      if ({enable, running} !== exp) begin
        bad++;
        $display("FAIL reset_release j=%0d got en/run=%b%b required %b", j, enable, running, exp);
      end
    end
  endtask

  task automatic test_run_rate01;
    logic [1:0] exp;
    plan_run(27, 2, 16, 6, 4, 16);
    for (int j = 0; j < 27; j++) begin
      drive(at2(j, 0) || at2(j, 15), 1'b0, 2'b01);
      exp = sb.pop_front();
      total++;
      if ({enable, running} !== exp) begin
        bad++;
        $display("FAIL run_rate01 j=%0d got en/run=%b%b required %b", j, enable, running, exp);
      end
    end
  endtask

  task automatic test_rate_p1;
    logic [1:0] exp;
    int en_cnt = 0;
    plan_run(18, 2, 14, 3, 1, 14);
    for (int j = 0; j < 18; j++) begin
      drive(at2(j, 0) || at2(j, 13), 1'b0, 2'b00);
      if (enable === 1'b1 && running === 1'b1) en_cnt++;
      exp = sb.pop_front();
      total++;
      if ({enable, running} !== exp) begin
        bad++;
        $display("FAIL rate_p1 j=%0d got en/run=%b%b required %b", j, enable, running, exp);
      end
    end
    total++;
    if (en_cnt !== 12) begin
      bad++;
      $display("FAIL rate_p1_count got %0d enable cycles required 12", en_cnt);
    end
  endtask

  task automatic test_step;
    logic [1:0] exp;
    for (int j = 0; j < 10; j++) sb.push_back(j == 3 ? 2'b10 : 2'b00);
    for (int j = 0; j < 10; j++) begin
      drive(1'b0, at2(j, 0), 2'b01);
      exp = sb.pop_front();
      total++;
      if ({enable, running} !== exp) begin
        bad++;
        $display("FAIL step_idle j=%0d got en/run=%b%b required %b", j, enable, running, exp);
      end
    end
    plan_run(25, 2, 20, 6, 4, 20);
    for (int j = 0; j < 25; j++) begin
      drive(at2(j, 0) || at2(j, 19), at2(j, 7), 2'b01);
      exp = sb.pop_front();
      total++;
      if ({enable, running} !== exp) begin
        bad++;
        $display("FAIL step_in_run j=%0d got en/run=%b%b required %b", j, enable, running, exp);
      end
    end
  endtask

  task automatic test_rate_change;
    logic [1:0] exp;
    for (int j = 0; j < 64; j++) begin
      logic en, rn;
      rn = (j >= 2) && (j <= 59);
      en = (j == 6) || (j >= 25 && j <= 59 && ((j - 25) % 16) == 0);
      sb.push_back({en, rn});
    end
    for (int j = 0; j < 64; j++) begin
      drive(at2(j, 0) || at2(j, 58), 1'b0, (j >= 9) ? 2'b11 : 2'b01);
      exp = sb.pop_front();
      total++;
      if ({enable, running} !== exp) begin
        bad++;
        $display("FAIL rate_change j=%0d got en/run=%b%b required %b", j, enable, running, exp);
      end
    end
  endtask

  task automatic test_run_step_same;
    logic [1:0] exp;
    plan_run(17, 2, 12, 6, 4, 12);
    for (int j = 0; j < 17; j++) begin
      drive(at2(j, 0) || at2(j, 11), at2(j, 0), 2'b01);
      exp = sb.pop_front();
      total++;
      if ({enable, running} !== exp) begin
        bad++;
        $display("FAIL run_step_same j=%0d got en/run=%b%b required %b", j, enable, running, exp);
      end
    end
  endtask

  task automatic test_reset_mid_run;
    logic [1:0] exp;
    plan_run(7, 2, 6, 6, 4, 6);
    for (int j = 0; j < 7; j++) begin
      drive(at2(j, 0), 1'b0, 2'b01);
      exp = sb.pop_front();
      total++;
      if ({enable, running} !== exp) begin
        bad++;
        $display("FAIL midrun_pre j=%0d got en/run=%b%b required %b", j, enable, running, exp);
      end
    end
    clearb = 1'b0;
    #1;
    total++;
    if ({enable, running} !== 2'b00) begin
      bad++;
      $display("FAIL midrun_async got en/run=%b%b required 00", enable, running);
    end
    drive(1'b0, 1'b0, 2'b01);
    drive(1'b0, 1'b0, 2'b01);
    clearb = 1'b1;
    for (int j = 0; j < 12; j++) sb.push_back(2'b00);
    for (int j = 0; j < 12; j++) begin
      drive(1'b0, 1'b0, 2'b01);
      exp = sb.pop_front();
      total++;
      if ({enable, running} !== exp) begin
        bad++;
        $display("FAIL midrun_quiet j=%0d got en/run=%b%b required %b", j, enable, running, exp);
      end
    end
    plan_run(12, 2, 8, 6, 4, 8);
    for (int j = 0; j < 12; j++) begin
      drive(at2(j, 0) || at2(j, 7), 1'b0, 2'b01);
      exp = sb.pop_front();
      total++;
      if ({enable, running} !== exp) begin
        bad++;
        $display("FAIL midrun_restart j=%0d got en/run=%b%b required %b", j, enable, running, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_run_rate01();
    test_rate_p1();
    test_step();
    test_rate_change();
    test_run_step_same();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
